latch_regfile: RTL and testbench
================================

Name: latch_regfile

Overview:
- Parametrised successor to the single-bit high-transparent D latch cell.
- A DEPTH x WIDTH storage array built from level-sensitive word latches, with a flop-staged write port, per-bit write mask and NUM_RD registered read ports.
- Used as a low-area register file or small buffer in place of flop arrays.
- The write side is fully synchronous to CK, so it can be timed with ordinary flop-based STA.

Parameters:
- WIDTH, 8: bits per word.
- DEPTH, 8: number of words; need not be a power of two.
- NUM_RD, 2: number of independent read ports.
- AW, $clog2(DEPTH) (minimum 1): address width.
- RST_VAL, 0: WIDTH-bit value loaded into every word on reset.

Ports:
- CK  input  1  clock; rising edge is the active edge.
- RN  input  1  reset, asynchronous, active-low.
- WE  input  1  write request, sampled on rising CK.
- WA  input  AW  write address.
- WD  input  WIDTH  write data.
- WM  input  WIDTH  per-bit write mask; 1 = bit written.
- RE  input  NUM_RD  per-port read enable.
- RA  input  NUM_RD*AW  packed read addresses; port p is RA[p*AW +: AW].
- RD  output  NUM_RD*WIDTH  packed registered read data; port p is RD[p*WIDTH +: WIDTH].

Behaviour:
- Reset, RN=0, asynchronous and dominant:
  - All words = RST_VAL; write staging (we_q, wa_q, wd_q, wm_q) = 0; RD = 0.
  - A pending staged write is discarded.
  - Word latches stay closed for as long as RN=0.
- Write, two phases:
  - Rising edge of cycle n: staging flops capture WE, WA, WD, WM.
  - Low phase of CK in cycle n: the latch enable for word wa_q is high, so that word is transparent, provided we_q=1, wa_q<DEPTH and RN=1.
  - While transparent: word[wa_q][b] follows wd_q[b] where wm_q[b]=1; bits with wm_q[b]=0 hold.
  - The latch closes on the rising edge of cycle n+1. Staging flops update at that same edge.
  - Implementation must guarantee the latch closes before the staging flops update: derive the enable from CK directly, with no zero-delay race; the staged-data hold path is required.
- Write address wa_q>=DEPTH: write dropped, no word changes.
- WM=0 with WE=1: no word changes.
- Read port p:
  - On rising CK with RE[p]=1: RD_p <= word[RA_p]. If RA_p>=DEPTH, RD_p <= 0.
  - RE[p]=0: RD_p holds.
  - Latency: 1 cycle from address to data.
- Read/write collisions:
  - Read at edge n of an address whose write was sampled at edge n returns OLD data, because the latch has not yet opened.
  - Read at edge n+1 of that address returns NEW data.
  - Multiple read ports may address the same word in the same cycle; all return identical data.
- Back-to-back writes to the same address in consecutive cycles: each write lands in its own low phase; the last one wins.
- Reset released mid-cycle:
  - No write may occur until the first rising edge after RN rises has staged a request. Staging is zero, so nothing is written before then.
  - RD stays 0 until the first enabled read edge.
- X handling: X on WE or WA while RN=1 drives the targeted word(s) to X in simulation. This is the equivalent of the cell NOTIFIER corruption.

Decomposition:
- Shared package latch_regfile_pkg holds:
  - the address-width function, clog2 with minimum 1;
  - the packed-port slice helpers;
  - the default RST_VAL constant.
- One natural sub-module: latch_regfile_word.
  - Contents: a WIDTH-bit masked word latch with async active-low reset and an enable input.
  - Instantiated DEPTH times under generate.
  - Top level holds the staging flops, write decode, enable gating and the NUM_RD read muxes with output flops.

Test Plan:
- Reset: RN=0 mid-run with RST_VAL=8'hA5 -> all words 8'hA5 and RD=0 immediately, without waiting for a CK edge; a write staged at the same time is discarded.
- Basic write/read: write WA=3, WD=8'h3C, WM=8'hFF at edge n; read RA0=3 at edge n+1 -> RD0=8'h3C after edge n+1.
- Masked write: word 3 = 8'h3C; write WD=8'hFF, WM=8'h0F -> readback 8'h3F.
- Collision: at edge n, write addr 5 = 8'h11 (old value 8'h00) and read port 0 addr 5 -> RD0=8'h00; repeat the read at edge n+1 -> RD0=8'h11.
- Out of range with DEPTH=6: write WA=7 -> no word changes; read RA1=6 with RE1=1 -> RD1=0.
- Dual read plus back-to-back writes: writes to addr 2 of 8'h01 then 8'h02 in consecutive cycles; both ports read addr 2 two cycles after the second write -> RD0=RD1=8'h02; with RE=0, RD holds its value.

Source files
------------

// File: rtl/latch_regfile_pkg.sv
// -----------------------------------------------------------------------------
// latch_regfile_pkg
// Shared definitions for the latch-based register file:
//   addr_width()  - address width for a given depth (clog2, never below 1)
//   port_lsb()    - LSB of port p inside a packed multi-port bus
//   DEFAULT_RST_VAL - default reset value loaded into every word
// -----------------------------------------------------------------------------
package latch_regfile_pkg;

  localparam int DEFAULT_RST_VAL = 0;

  // A depth of 1 or 2 still needs one address bit so ports never collapse
  // to zero width.
  function automatic int addr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/latch_regfile_word.sv
// -----------------------------------------------------------------------------
// latch_regfile_word
// One WIDTH-bit storage word built from level-sensitive latches.
//   i_en  - latch enable; word is transparent while high
//   i_rn  - asynchronous active-low reset, loads RST_VAL and keeps word closed
//   i_wd  - write data
//   i_wm  - per-bit write mask, 1 = bit follows i_wd while enabled
//   o_q   - stored word
// -----------------------------------------------------------------------------
module latch_regfile_word #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_en,
  input  logic             i_rn,
  input  logic [WIDTH-1:0] i_wd,
  input  logic [WIDTH-1:0] i_wm,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // NOTE: storage elements use non-blocking assignments, latches included;
  // masked bits are simply not assigned so they hold without a feedback path.
  always_latch begin
    if (!i_rn) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (i_wm[b]) r_q[b] <= i_wd[b];
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/latch_regfile.sv
// -----------------------------------------------------------------------------
// latch_regfile
// DEPTH x WIDTH register file made of word latches, with a flop-staged masked
// write port and NUM_RD registered read ports (1-cycle latency).
//   CK  - clock, rising edge active
//   RN  - asynchronous active-low reset
//   WE/WA/WD/WM - write request, address, data, per-bit mask (sampled on CK)
//   RE  - per-port read enable
//   RA  - packed read addresses, port p at RA[p*AW +: AW]
//   RD  - packed registered read data, port p at RD[p*WIDTH +: WIDTH]
// A write staged at edge n is applied during the low phase of cycle n; the
// target latch closes at edge n+1, exactly when the staging flops update.
// -----------------------------------------------------------------------------
module latch_regfile
  import latch_regfile_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 8,
  parameter int               NUM_RD  = 2,
  parameter int               AW      = addr_width(DEPTH),
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEFAULT_RST_VAL)
) (
  input  logic                    CK,
  input  logic                    RN,
  input  logic                    WE,
  input  logic [AW-1:0]           WA,
  input  logic [WIDTH-1:0]        WD,
  input  logic [WIDTH-1:0]        WM,
  input  logic [NUM_RD-1:0]       RE,
  input  logic [NUM_RD*AW-1:0]    RA,
  output logic [NUM_RD*WIDTH-1:0] RD
);

  // Write staging
  logic             r_we;
  logic [AW-1:0]    r_wa;
  logic [WIDTH-1:0] r_wd;
  logic [WIDTH-1:0] r_wm;

  // NOTE: reset clears the staging flops so a pending write is discarded and
  // nothing can be written until a fresh request is staged after release.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_we <= 1'b0;
      r_wa <= '0;
      r_wd <= '0;
      r_wm <= '0;
    end else begin
      r_we <= WE;
      r_wa <= WA;
      r_wd <= WD;
      r_wm <= WM;
    end
  end

  // Storage array
  logic [DEPTH-1:0] w_en;
  logic [WIDTH-1:0] w_word [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    // Enable is gated directly by ~CK: it falls on the rising edge itself,
    // so the latch closes before the staging flops present new data.
    // Addresses >= DEPTH match no word and the write is dropped.
    assign w_en[i] = ~CK & RN & r_we & (r_wa == AW'(i));

    latch_regfile_word #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_word (
      .i_en (w_en[i]),
      .i_rn (RN),
      .i_wd (r_wd),
      .i_wm (r_wm),
      .o_q  (w_word[i])
    );
  end

  // Read ports
  logic [AW-1:0]    w_ra     [NUM_RD];
  logic [WIDTH-1:0] w_rd_mux [NUM_RD];
  logic [WIDTH-1:0] r_rd     [NUM_RD];

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    assign w_ra[p] = RA[port_lsb(p, AW) +: AW];
    assign RD[port_lsb(p, WIDTH) +: WIDTH] = r_rd[p];
  end

  // Out-of-range addresses select nothing and read as zero.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      w_rd_mux[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_ra[p] == AW'(i)) w_rd_mux[p] = w_word[i];
      end
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      for (int p = 0; p < NUM_RD; p++) r_rd[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (RE[p]) r_rd[p] <= w_rd_mux[p];
      end
    end
  end

endmodule

// File: tb/tb_latch_regfile.sv
// -----------------------------------------------------------------------------
// tb_latch_regfile
// Directed bench for latch_regfile (DEPTH=6, RST_VAL=8'hA5). A memory-array
// model tracks expected contents and read data; every falling edge compares
// both read ports against it, and literal checks pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_latch_regfile;

  localparam int         W  = 8;
  localparam int         D  = 6;
  localparam int         N  = 2;
  localparam int         AW = 3;
  localparam logic [7:0] RV = 8'hA5;

  logic           CK = 1'b0;
  logic           RN;
  logic           WE;
  logic [AW-1:0]  WA;
  logic [W-1:0]   WD;
  logic [W-1:0]   WM;
  logic [N-1:0]   RE;
  logic [N*AW-1:0] RA;
  logic [N*W-1:0] RD;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] m_mem [D];
  logic [7:0] m_rd  [N];

  latch_regfile #(
    .WIDTH   (W),
    .DEPTH   (D),
    .NUM_RD  (N),
    .AW      (AW),
    .RST_VAL (RV)
  ) dut (
    .CK (CK),
    .RN (RN),
    .WE (WE),
    .WA (WA),
    .WD (WD),
    .WM (WM),
    .RE (RE),
    .RA (RA),
    .RD (RD)
  );

  always #5 CK = ~CK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: reset fills memory, reads see memory as it stood before the
  // same-edge write, and a write becomes visible from the next edge on.
  task automatic model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = RV;
    for (int p = 0; p < N; p++) m_rd[p] = 8'h00;
  endtask

  always @(negedge RN) model_reset();

  always @(posedge CK) begin : model
    int a;
    if (RN === 1'b1) begin
      for (int p = 0; p < N; p++) begin
        if (RE[p]) begin
          a = int'(RA[p*AW +: AW]);
          m_rd[p] = (a < D) ? m_mem[a] : 8'h00;
        end
      end
      if (WE && int'(WA) < D)
        m_mem[WA] = (m_mem[WA] & ~WM) | (WD & WM);
    end
  end

  always @(negedge CK) begin
    for (int p = 0; p < N; p++)
      check($sformatf("model_rd%0d", p), RD[p*W +: W], m_rd[p]);
  end

  // Apply one cycle of stimulus at a falling edge; returns at the next
  // falling edge, when the read issued here is visible on RD.
  task automatic cycle(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic [7:0] wm, input logic [1:0] re,
                       input logic [2:0] ra0, input logic [2:0] ra1);
    WE = we; WA = wa; WD = wd; WM = wm; RE = re; RA = {ra1, ra0};
    @(negedge CK);
  endtask

  initial begin
    RN = 1'b0; WE = 1'b0; WA = '0; WD = '0; WM = '0; RE = '0; RA = '0;
    model_reset();
    repeat (2) @(negedge CK);
    check("reset_rd0", RD[7:0], 8'h00);
    check("reset_rd1", RD[15:8], 8'h00);
    RN = 1'b1;

    // Reset contents
    cycle(0, 0, 8'h00, 8'h00, 2'b11, 0, 5);
    check("reset_word0", RD[7:0], RV);
    check("reset_word5", RD[15:8], RV);

    // Basic write then read
    cycle(1, 3, 8'h3C, 8'hFF, 2'b00, 0, 0);
    cycle(0, 0, 8'h00, 8'h00, 2'b01, 3, 0);
    check("basic_wr", RD[7:0], 8'h3C);

    // Masked write
    cycle(1, 3, 8'hFF, 8'h0F, 2'b00, 0, 0);
    cycle(0, 0, 8'h00, 8'h00, 2'b01, 3, 0);
    check("masked_wr", RD[7:0], 8'h3F);

    // Collision: old data at the write edge, new data one edge later
    cycle(1, 5, 8'h00, 8'hFF, 2'b00, 0, 0);
    cycle(0, 0, 8'h00, 8'h00, 2'b00, 0, 0);
    cycle(1, 5, 8'h11, 8'hFF, 2'b01, 5, 0);
    check("coll_old", RD[7:0], 8'h00);
    cycle(0, 0, 8'h00, 8'h00, 2'b01, 5, 0);
    check("coll_new", RD[7:0], 8'h11);

    // Out of range write and read; port 0 holds while disabled
    cycle(1, 7, 8'hEE, 8'hFF, 2'b10, 0, 6);
    check("oor_rd1", RD[15:8], 8'h00);
    check("hold_rd0", RD[7:0], 8'h11);

    // Zero-mask write changes nothing
    cycle(1, 4, 8'hFF, 8'h00, 2'b00, 0, 0);
    cycle(0, 0, 8'h00, 8'h00, 2'b01, 4, 0);
    check("nomask_wr", RD[7:0], RV);

    // Sweep every word through both ports
    for (int i = 0; i < D; i += 2)
      cycle(0, 0, 8'h00, 8'h00, 2'b11, 3'(i), 3'(i + 1));

    // Back-to-back writes, dual read, then hold
    cycle(1, 2, 8'h01, 8'hFF, 2'b00, 0, 0);
    cycle(1, 2, 8'h02, 8'hFF, 2'b00, 0, 0);
    cycle(0, 0, 8'h00, 8'h00, 2'b00, 0, 0);
    cycle(0, 0, 8'h00, 8'h00, 2'b11, 2, 2);
    check("b2b_rd0", RD[7:0], 8'h02);
    check("b2b_rd1", RD[15:8], 8'h02);
    cycle(0, 0, 8'h00, 8'h00, 2'b00, 0, 5);
    check("hold_b2b_rd0", RD[7:0], 8'h02);
    check("hold_b2b_rd1", RD[15:8], 8'h02);

    // Mid-run reset while a write is staged
    WE = 1'b1; WA = 3'd1; WD = 8'h55; WM = 8'hFF; RE = 2'b00;
    @(posedge CK);
    #1 RN = 1'b0;
    #1;
    check("async_rd0", RD[7:0], 8'h00);
    check("async_rd1", RD[15:8], 8'h00);
    WE = 1'b0;
    @(negedge CK);
    #2 RN = 1'b1;
    cycle(0, 0, 8'h00, 8'h00, 2'b11, 1, 3);
    check("post_rst_w1", RD[7:0], RV);
    check("post_rst_w3", RD[15:8], RV);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
